// File: rtl/score_pkg.sv
// Shared constants, types and the double-dabble step used by the score sequencer.
package score_pkg;

  localparam int SCORE_W    = 17;
  localparam int MAX_SCORE  = 99999;
  localparam int BCD_DIGITS = 5;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  // One shift-add-3 step: correct every digit >= 5, then shift in the next binary bit.
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] bcd_in,
                                               input logic bit_in);
    logic [BCD_W-1:0] adj;
    adj = bcd_in;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (adj[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
      end else begin
        adj[4*d +: 4] = adj[4*d +: 4];
      end
    end
    return {adj[BCD_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/score_sequencer_if.sv
// Add-request handshake bundle between the point sources and the score sequencer.
interface score_sequencer_if #(
  parameter int NUM_REQ = 2,
  parameter int VAL_W   = 8
);
  logic [NUM_REQ-1:0]       add_req;
  logic [NUM_REQ*VAL_W-1:0] add_val;
  logic [NUM_REQ-1:0]       add_ack;

  modport master (output add_req, output add_val, input add_ack);
  modport slave  (input add_req, input add_val, output add_ack);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first eligible requester starting at ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic               enable,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [PTR_W-1:0]   ptr_next
);

  logic [NUM_REQ-1:0] elig_s;

  // Scan requesters in rotated order and grant the first unmasked one.
  always_comb begin
    int idx;
    idx         = 0;
    elig_s      = req & ~mask & {NUM_REQ{enable}};
    grant       = '0;
    grant_valid = 1'b0;
    ptr_next    = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!grant_valid && elig_s[idx]) begin
        grant[idx]  = 1'b1;
        grant_valid = 1'b1;
        ptr_next    = PTR_W'((idx + 1) % NUM_REQ);
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/score_sequencer.sv
// Saturating score accumulator with round-robin add arbitration and an
// iterative binary-to-BCD converter feeding the display digits.
module score_sequencer #(
  parameter int NUM_REQ   = 2,
  parameter int VAL_W     = 8,
  parameter int SCORE_W   = score_pkg::SCORE_W,
  parameter int MAX_SCORE = score_pkg::MAX_SCORE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  score_sequencer_if.slave      add_bus,
  output logic [SCORE_W-1:0]    score,
  output score_pkg::bcd_digit_t digit4,
  output score_pkg::bcd_digit_t digit3,
  output score_pkg::bcd_digit_t digit2,
  output score_pkg::bcd_digit_t digit1,
  output score_pkg::bcd_digit_t digit0,
  output logic                  digits_valid,
  output logic                  busy
);
  import score_pkg::*;

  localparam int               PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int               CNT_W   = $clog2(SCORE_W);
  localparam logic [SCORE_W:0] MAX_EXT = (SCORE_W + 1)'(MAX_SCORE);

  state_t             state_r, state_next_s;
  logic [SCORE_W-1:0] score_r, score_next_s, snap_r;
  logic [SCORE_W:0]   sum_s;
  logic [BCD_W-1:0]   bcd_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [NUM_REQ-1:0] add_ack_r, grant_s;
  logic [PTR_W-1:0]   rr_ptr_r, ptr_next_s;
  logic [VAL_W-1:0]   sel_val_s;
  logic               grant_valid_s, score_evt_s;
  logic               dirty_r, valid_r, busy_r;
  logic               snap_en_s, step_en_s, load_en_s;
  bcd_digit_t         digit_r [BCD_DIGITS];

  // A source is masked while its ack is high so a held request is counted once.
  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req         (add_bus.add_req),
    .mask        (add_ack_r),
    .enable      (!clear),
    .ptr         (rr_ptr_r),
    .grant       (grant_s),
    .grant_valid (grant_valid_s),
    .ptr_next    (ptr_next_s)
  );

  // Select the granted source's value from the packed value bus.
  always_comb begin
    sel_val_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_val_s = sel_val_s | (add_bus.add_val[i*VAL_W +: VAL_W] & {VAL_W{grant_s[i]}});
    end
  end

  // Next score: clear wins, otherwise a saturating add of the granted value.
  always_comb begin
    sum_s = {1'b0, score_r} + {{(SCORE_W + 1 - VAL_W){1'b0}}, sel_val_s};
    if (clear) begin
      score_next_s = '0;
      score_evt_s  = 1'b1;
    end else if (grant_valid_s) begin
      score_next_s = (sum_s > MAX_EXT) ? MAX_EXT[SCORE_W-1:0] : sum_s[SCORE_W-1:0];
      score_evt_s  = 1'b1;
    end else begin
      score_next_s = score_r;
      score_evt_s  = 1'b0;
    end
  end

  // Converter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Converter next-state: idle until dirty, SCORE_W steps, then one load cycle.
  always_comb begin
    case (state_r)
      IDLE:    state_next_s = dirty_r ? CONV : IDLE;
      CONV:    state_next_s = (cnt_r == CNT_W'(SCORE_W - 1)) ? LOAD : CONV;
      LOAD:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Converter control strobes decoded from the current state.
  always_comb begin
    case (state_r)
      IDLE: begin
        snap_en_s = dirty_r;
        step_en_s = 1'b0;
        load_en_s = 1'b0;
      end
      CONV: begin
        snap_en_s = 1'b0;
        step_en_s = 1'b1;
        load_en_s = 1'b0;
      end
      LOAD: begin
        snap_en_s = 1'b0;
        step_en_s = 1'b0;
        load_en_s = 1'b1;
      end
      default: begin
        snap_en_s = 1'b0;
        step_en_s = 1'b0;
        load_en_s = 1'b0;
      end
    endcase
  end

  // Score, handshake, pointer, converter datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_r   <= '0;
      add_ack_r <= '0;
      rr_ptr_r  <= '0;
      dirty_r   <= 1'b0;
      snap_r    <= '0;
      bcd_r     <= '0;
      cnt_r     <= '0;
      valid_r   <= 1'b1;
      busy_r    <= 1'b0;
      for (int d = 0; d < BCD_DIGITS; d++) begin
        digit_r[d] <= 4'd0;
      end
    end else begin
      score_r   <= score_next_s;
      add_ack_r <= grant_s;
      rr_ptr_r  <= ptr_next_s;
      busy_r    <= (state_next_s != IDLE);
      // A new score event must survive the snapshot taken on the same edge.
      if (score_evt_s) begin
        dirty_r <= 1'b1;
      end else if (snap_en_s) begin
        dirty_r <= 1'b0;
      end else begin
        dirty_r <= dirty_r;
      end
      if (snap_en_s) begin
        snap_r <= score_r;
        bcd_r  <= '0;
        cnt_r  <= '0;
      end else if (step_en_s) begin
        bcd_r  <= dd_step(bcd_r, snap_r[SCORE_W-1]);
        snap_r <= snap_r << 1;
        cnt_r  <= cnt_r + CNT_W'(1);
      end else begin
        snap_r <= snap_r;
      end
      if (load_en_s) begin
        for (int d = 0; d < BCD_DIGITS; d++) begin
          digit_r[d] <= bcd_r[4*d +: 4];
        end
      end
      if (score_next_s != score_r) begin
        valid_r <= 1'b0;
      end else if (load_en_s) begin
        valid_r <= !dirty_r;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign add_bus.add_ack = add_ack_r;
  assign score           = score_r;
  assign digit4          = digit_r[4];
  assign digit3          = digit_r[3];
  assign digit2          = digit_r[2];
  assign digit1          = digit_r[1];
  assign digit0          = digit_r[0];
  assign digits_valid    = valid_r;
  assign busy            = busy_r;

endmodule

// File: tb/tb_score_sequencer.sv
// Directed self-checking bench for score_sequencer.
module tb_score_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [16:0] score;
  logic [3:0]  digit4, digit3, digit2, digit1, digit0;
  logic        digits_valid;
  logic        busy;
  int          check_cnt = 0;
  int          pass_cnt  = 0;

  score_sequencer_if #(.NUM_REQ(2), .VAL_W(8)) bus ();

  score_sequencer #(.NUM_REQ(2), .VAL_W(8), .SCORE_W(17), .MAX_SCORE(99999)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .add_bus      (bus),
    .score        (score),
    .digit4       (digit4),
    .digit3       (digit3),
    .digit2       (digit2),
    .digit1       (digit1),
    .digit0       (digit0),
    .digits_valid (digits_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    clear = 1'b0;
    bus.add_req = 2'b00;
    bus.add_val = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_add(input int src, input logic [7:0] val);
    bus.add_val[src*8 +: 8] = val;
    bus.add_req[src] = 1'b1;
    tick();
    bus.add_req[src] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_dut();
    check_cnt++;
    if (score !== 17'd0) $display("FAIL reset_score: got %0d expected 0", score);
    else pass_cnt++;
    check_cnt++;
    if ({digit4, digit3, digit2, digit1, digit0} !== 20'h00000)
      $display("FAIL reset_digits: got %05h expected 00000", {digit4, digit3, digit2, digit1, digit0});
    else pass_cnt++;
    check_cnt++;
    if ({digits_valid, busy, bus.add_ack} !== 4'b1000)
      $display("FAIL reset_flags: got valid/busy/ack %b expected 1000", {digits_valid, busy, bus.add_ack});
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({digits_valid, busy, bus.add_ack, score} !== {4'b1000, 17'd0})
      $display("FAIL idle_after_reset: got %0h expected %0h", {digits_valid, busy, bus.add_ack, score}, {4'b1000, 17'd0});
    else pass_cnt++;
  endtask

  task automatic test_single_add();
    bus.add_val[7:0] = 8'd37;
    bus.add_req[0] = 1'b1;
    tick();
    check_cnt++;
    if ({bus.add_ack, score} !== {2'b01, 17'd37})
      $display("FAIL single_ack: got ack %b score %0d expected ack 01 score 37", bus.add_ack, score);
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({bus.add_ack, score} !== {2'b00, 17'd37})
      $display("FAIL single_held: got ack %b score %0d expected ack 00 score 37", bus.add_ack, score);
    else pass_cnt++;
    bus.add_req[0] = 1'b0;
    repeat (17) tick();
    check_cnt++;
    if ({digits_valid, busy} !== 2'b01)
      $display("FAIL single_converting: got valid/busy %b expected 01", {digits_valid, busy});
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({digit4, digit3, digit2, digit1, digit0, digits_valid, busy} !== {20'h00037, 2'b10})
      $display("FAIL single_digits: got %05h valid %b busy %b expected 00037 valid 1 busy 0",
               {digit4, digit3, digit2, digit1, digit0}, digits_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_ack [4];
    logic [16:0] exp_score [4];
    int n;
    exp_ack   = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_score = '{17'd5, 17'd14, 17'd19, 17'd28};
    reset_dut();
    bus.add_val = {8'd9, 8'd5};
    bus.add_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_cnt++;
      if ({bus.add_ack, score} !== {exp_ack[k], exp_score[k]})
        $display("FAIL rr_step%0d: got ack %b score %0d expected ack %b score %0d",
                 k, bus.add_ack, score, exp_ack[k], exp_score[k]);
      else pass_cnt++;
    end
    bus.add_req = 2'b00;
    n = 0;
    tick();
    while (!(digits_valid && !busy) && n < 100) begin
      tick();
      n++;
    end
    check_cnt++;
    if (n >= 100) $display("FAIL rr_settle: got timeout after %0d cycles expected valid digits", n);
    else pass_cnt++;
    check_cnt++;
    if ({digit4, digit3, digit2, digit1, digit0} !== 20'h00028)
      $display("FAIL rr_digits: got %05h expected 00028", {digit4, digit3, digit2, digit1, digit0});
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    int n;
    reset_dut();
    repeat (392) do_add(0, 8'd255);
    do_add(1, 8'd30);
    check_cnt++;
    if (score !== 17'd99990) $display("FAIL sat_preload: got %0d expected 99990", score);
    else pass_cnt++;
    bus.add_val[7:0] = 8'd200;
    bus.add_req[0] = 1'b1;
    tick();
    check_cnt++;
    if ({bus.add_ack, score} !== {2'b01, 17'd99999})
      $display("FAIL sat_clip: got ack %b score %0d expected ack 01 score 99999", bus.add_ack, score);
    else pass_cnt++;
    bus.add_req[0] = 1'b0;
    n = 0;
    tick();
    while (!(digits_valid && !busy) && n < 100) begin
      tick();
      n++;
    end
    check_cnt++;
    if (n >= 100) $display("FAIL sat_settle: got timeout after %0d cycles expected valid digits", n);
    else pass_cnt++;
    check_cnt++;
    if ({digit4, digit3, digit2, digit1, digit0} !== 20'h99999)
      $display("FAIL sat_digits: got %05h expected 99999", {digit4, digit3, digit2, digit1, digit0});
    else pass_cnt++;
    bus.add_val[7:0] = 8'd1;
    bus.add_req[0] = 1'b1;
    tick();
    check_cnt++;
    if ({bus.add_ack, score} !== {2'b01, 17'd99999})
      $display("FAIL sat_hold: got ack %b score %0d expected ack 01 score 99999", bus.add_ack, score);
    else pass_cnt++;
    bus.add_req[0] = 1'b0;
    tick();
  endtask

  task automatic test_add_during_conv();
    reset_dut();
    do_add(0, 8'd10);
    repeat (3) tick();
    check_cnt++;
    if (busy !== 1'b1) $display("FAIL conv_busy: got %b expected 1", busy);
    else pass_cnt++;
    bus.add_val[15:8] = 8'd20;
    bus.add_req[1] = 1'b1;
    tick();
    check_cnt++;
    if ({bus.add_ack, score} !== {2'b10, 17'd30})
      $display("FAIL conv_add: got ack %b score %0d expected ack 10 score 30", bus.add_ack, score);
    else pass_cnt++;
    bus.add_req[1] = 1'b0;
    tick();
    repeat (13) tick();
    check_cnt++;
    if ({digit4, digit3, digit2, digit1, digit0, digits_valid} !== {20'h00010, 1'b0})
      $display("FAIL conv_stale_load: got %05h valid %b expected 00010 valid 0",
               {digit4, digit3, digit2, digit1, digit0}, digits_valid);
    else pass_cnt++;
    repeat (18) tick();
    check_cnt++;
    if ({digits_valid, busy} !== 2'b01)
      $display("FAIL conv_second_run: got valid/busy %b expected 01", {digits_valid, busy});
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({digit4, digit3, digit2, digit1, digit0, digits_valid} !== {20'h00030, 1'b1})
      $display("FAIL conv_final_load: got %05h valid %b expected 00030 valid 1",
               {digit4, digit3, digit2, digit1, digit0}, digits_valid);
    else pass_cnt++;
  endtask

  task automatic test_clear_reset();
    clear = 1'b1;
    bus.add_val[15:8] = 8'd7;
    bus.add_req[1] = 1'b1;
    tick();
    check_cnt++;
    if ({bus.add_ack, score} !== {2'b00, 17'd0})
      $display("FAIL clear_prio: got ack %b score %0d expected ack 00 score 0", bus.add_ack, score);
    else pass_cnt++;
    clear = 1'b0;
    tick();
    check_cnt++;
    if ({bus.add_ack, score} !== {2'b10, 17'd7})
      $display("FAIL clear_pending: got ack %b score %0d expected ack 10 score 7", bus.add_ack, score);
    else pass_cnt++;
    bus.add_req[1] = 1'b0;
    tick();
    repeat (3) tick();
    check_cnt++;
    if (busy !== 1'b1) $display("FAIL reset_pre_busy: got %b expected 1", busy);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_cnt++;
    if ({busy, digits_valid, bus.add_ack, score} !== {4'b0100, 17'd0})
      $display("FAIL reset_abort_flags: got busy %b valid %b ack %b score %0d expected busy 0 valid 1 ack 00 score 0",
               busy, digits_valid, bus.add_ack, score);
    else pass_cnt++;
    check_cnt++;
    if ({digit4, digit3, digit2, digit1, digit0} !== 20'h00000)
      $display("FAIL reset_abort_digits: got %05h expected 00000", {digit4, digit3, digit2, digit1, digit0});
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    bus.add_req = 2'b00;
    bus.add_val = 16'h0000;
    test_reset();
    test_single_add();
    test_round_robin();
    test_saturate();
    test_add_during_conv();
    test_clear_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
